// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory arbiter slice.
//   word_t         : 32-bit machine word
//   arb_state_t    : arbiter FSM states
//   ARB_DSTREAK_W  : width of the data-grant streak counter
//   dstreak_inc()  : saturating increment for the streak counter
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    SCFAIL
  } arb_state_t;

  localparam int unsigned ARB_DSTREAK_W = 4;

  function automatic logic [ARB_DSTREAK_W-1:0] dstreak_inc(input logic [ARB_DSTREAK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/link_reg.sv
// LL/SC link register.
//   CLK, RST     : clock, synchronous active-high reset
//   set          : capture addr and mark the link valid (LL completion)
//   clear_all    : unconditionally invalidate (successful SC)
//   clear_match  : invalidate if addr equals the linked address (any write)
//   addr         : address used for set, match-clear and compare
//   sc_ok        : link valid and linked address equals addr (combinational)
module link_reg #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set,
  input  logic              clear_all,
  input  logic              clear_match,
  input  logic [ADDR_W-1:0] addr,
  output logic              sc_ok
);

  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;
  logic              addr_match;

  assign addr_match = (link_addr == addr);
  assign sc_ok      = link_valid && addr_match;

  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end else if (clear_all || (clear_match && addr_match)) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between instruction fetch and data access,
// with LL/SC link semantics. Data has priority; after DSTREAK_MAX
// consecutive data grants with a fetch pending, one fetch is forced.
//   CLK, RST                    : clock, synchronous active-high reset
//   iREN, iaddr / ihit, iload   : instruction request / completion
//   dREN, dWEN, datomic, daddr,
//   dstore / dhit, dload        : data request / completion (SC: dload=1 ok)
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ram_ready : RAM side
// Optional build macro ARB_PERF_EN adds icount, dcount, stall_cycles
// (32-bit wrapping event counters) as extra outputs.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output word_t             iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output logic              dhit,
  output word_t             dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  logic              ram_ready
`ifdef ARB_PERF_EN
  ,
  output word_t             icount,
  output word_t             dcount,
  output word_t             stall_cycles
`endif
);

  localparam logic [ARB_DSTREAK_W-1:0] DMAX = DSTREAK_MAX[ARB_DSTREAK_W-1:0];

  arb_state_t               state, state_next;
  logic [ARB_DSTREAK_W-1:0] dstreak, dstreak_next;

  logic d_pend, is_ll, is_sc;
  logic link_set, link_clear_all, link_clear_match, sc_ok;

  assign d_pend = dREN | dWEN;
  assign is_ll  = dREN & datomic;
  assign is_sc  = dWEN & datomic;

  link_reg #(.ADDR_W(ADDR_W)) u_link (
    .CLK         (CLK),
    .RST         (RST),
    .set         (link_set),
    .clear_all   (link_clear_all),
    .clear_match (link_clear_match),
    .addr        (daddr),
    .sc_ok       (sc_ok)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      state   <= state_next;
      dstreak <= dstreak_next;
    end
  end

  // Outputs are forced low while RST is asserted so an access being
  // abandoned cannot complete in the reset cycle.
  always_comb begin
    state_next       = state;
    dstreak_next     = dstreak;
    ihit             = 1'b0;
    iload            = '0;
    dhit             = 1'b0;
    dload            = '0;
    ramREN           = 1'b0;
    ramWEN           = 1'b0;
    ramaddr          = '0;
    ramstore         = '0;
    link_set         = 1'b0;
    link_clear_all   = 1'b0;
    link_clear_match = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (d_pend && !(iREN && (dstreak == DMAX))) begin
            state_next = (is_sc && !sc_ok) ? SCFAIL : DACC;
            if (iREN) dstreak_next = dstreak_inc(dstreak);
          end else if (iREN) begin
            state_next   = IACC;
            dstreak_next = '0;
          end
        end
        IACC: begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_ready) begin
            ihit       = 1'b1;
            iload      = ramload;
            state_next = IDLE;
          end
        end
        DACC: begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_ready) begin
            dhit             = 1'b1;
            dload            = dREN ? ramload : (datomic ? word_t'(1) : '0);
            link_set         = is_ll;
            link_clear_all   = is_sc;
            link_clear_match = dWEN;
            state_next       = IDLE;
          end
        end
        SCFAIL: begin
          dhit       = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  // A stall cycle is any cycle with a request pending and no completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount       <= '0;
      dcount       <= '0;
      stall_cycles <= '0;
    end else begin
      icount       <= icount + word_t'(ihit);
      dcount       <= dcount + word_t'(dhit);
      stall_cycles <= stall_cycles + word_t'((iREN | d_pend) & ~ihit & ~dhit);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected responses
// computed from a behavioural memory/link model; a monitor pops and
// compares on every ihit/dhit.
module tb_mem_arbiter;

  localparam int DMAX = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN, dWEN, datomic;
  logic [31:0] daddr, dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
`ifdef ARB_PERF_EN
  logic [31:0] icount, dcount, stall_cycles;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(.DSTREAK_MAX(DMAX), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
`ifdef ARB_PERF_EN
    , .icount(icount), .dcount(dcount), .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- counters and check helper ----------------
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- RAM and reference model ----------------
  logic [31:0] ram [logic [31:0]];
  logic [31:0] mdl [logic [31:0]];
  bit          m_lv;
  logic [31:0] m_la;
  int          rdy_mode; // 0 random, 1 always ready, 2 never ready

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  function logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_val(a);
  endfunction

  initial begin
    ram_ready = 1'b0;
    ramload   = '0;
    forever begin
      @(posedge CLK);
      #2;
      case (rdy_mode)
        0:       ram_ready = ($urandom_range(0, 99) < 55);
        1:       ram_ready = 1'b1;
        default: ram_ready = 1'b0;
      endcase
      ramload = ramREN ? ram_rd(ramaddr) : $urandom;
      @(negedge CLK);
      if (!RST && ramWEN && ram_ready) ram[ramaddr] = ramstore;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          kind;  // 0 LW, 1 SW, 2 LL, 3 SC
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] exp;
    bit          wr;
  } dop_t;

  dop_t        dq[$];
  logic [31:0] iq[$];
  int          hit_log[$]; // 1 = instruction, 0 = data

  bit          wr_seen, p_i, p_d;
  logic [31:0] w_addr, w_data;
  int          streak;

  always @(negedge CLK) begin
    if (RST) begin
      wr_seen = 0; p_i = 0; p_d = 0; streak = 0;
    end else begin
      if (ramWEN) begin
        wr_seen = 1; w_addr = ramaddr; w_data = ramstore;
      end
      if (ihit || dhit) chk("hit_exclusive", 32'(ihit & dhit), 0);
      if (ihit) begin
        chk("ihit_pulse", 32'(p_i), 0);
        if (iq.size() == 0) chk("ihit_unexpected", 1, 0);
        else chk("iload", iload, iq.pop_front());
        hit_log.push_back(1);
        streak = 0;
      end
      if (dhit) begin
        chk("dhit_pulse", 32'(p_d), 0);
        if (iREN) streak++;
        chk("dstreak_bound", 32'(streak > DMAX + 1), 0);
        if (dq.size() == 0) chk("dhit_unexpected", 1, 0);
        else begin
          dop_t op;
          op = dq.pop_front();
          chk("dload", dload, op.exp);
          chk("ram_write_issued", 32'(wr_seen), 32'(op.wr));
          if (op.wr) begin
            chk("ram_write_addr", w_addr, op.addr);
            chk("ram_write_data", w_data, op.store);
          end
        end
        wr_seen = 0;
        hit_log.push_back(0);
      end
      if (!iREN) streak = 0;
      p_i = ihit;
      p_d = dhit;
    end
  end

  // ---------------- requesters (called at posedge+1, return at posedge+1) ----------------
  task automatic data_op(input int kind, input logic [31:0] a, input logic [31:0] st);
    dop_t op;
    bit got;
    op.kind = kind; op.addr = a; op.store = st; op.exp = '0; op.wr = 0;
    case (kind)
      0: op.exp = mdl_rd(a);
      1: begin
        mdl[a] = st; op.wr = 1;
        if (m_lv && m_la == a) m_lv = 0;
      end
      2: begin
        op.exp = mdl_rd(a); m_lv = 1; m_la = a;
      end
      default: begin
        if (m_lv && m_la == a) begin
          mdl[a] = st; op.wr = 1; op.exp = 1; m_lv = 0;
        end
      end
    endcase
    dq.push_back(op);
    dREN    = (kind == 0 || kind == 2);
    dWEN    = (kind == 1 || kind == 3);
    datomic = (kind >= 2);
    daddr   = a;
    dstore  = st;
    got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (dhit) begin got = 1; break; end
    end
    chk("data_hit_within_budget", 32'(got), 1);
    @(posedge CLK); #1;
  endtask

  task automatic data_drop();
    dREN = 0; dWEN = 0; datomic = 0;
  endtask

  task automatic inst_op(input logic [31:0] a);
    bit got;
    iq.push_back(mdl_rd(a));
    iREN  = 1;
    iaddr = a;
    got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (ihit) begin got = 1; break; end
    end
    chk("inst_hit_within_budget", 32'(got), 1);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST  = 1;
    m_lv = 0;
    @(negedge CLK);
    chk("rst_hits_enables", {28'd0, ihit, dhit, ramREN, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_loads", iload | dload | ramstore, 0);
    @(posedge CLK); #1;
    RST = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int exp_order[6];
    RST = 1; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; datomic = 0;
    daddr = '0; dstore = '0; rdy_mode = 1; m_lv = 0; m_la = '0;
    ram[32'h40] = 32'h3C010001;
    mdl[32'h40] = 32'h3C010001;
    @(posedge CLK); #1;
    do_reset();

    // 1: single fetch, ready always high
    iq.push_back(32'h3C010001);
    iREN = 1; iaddr = 32'h40;
    @(negedge CLK);
    chk("t1_grant_cycle_ihit", 32'(ihit), 0);
    @(negedge CLK);
    chk("t1_iacc_ramREN", 32'(ramREN), 1);
    chk("t1_iacc_ramaddr", ramaddr, 32'h40);
    chk("t1_ihit", 32'(ihit), 1);
    @(posedge CLK); #1;
    iREN = 0;
    @(posedge CLK); #1;

    // 2: starvation limit
    do_reset();
    hit_log.delete();
    fork
      begin inst_op(32'h1004); iREN = 0; end
      begin for (int k = 0; k < 6; k++) data_op(0, 32'h100, 0); data_drop(); end
    join
    exp_order = '{0, 0, 0, 0, 1, 0};
    chk("t2_hit_count", 32'(hit_log.size()), 7);
    for (int i = 0; i < 6; i++)
      if (i < hit_log.size()) chk($sformatf("t2_order_%0d", i), 32'(hit_log[i]), 32'(exp_order[i]));

    // 3: LL/SC success then repeat SC fails
    data_op(2, 32'h200, 0);
    data_op(3, 32'h200, 32'hAA);
    data_op(3, 32'h200, 32'hBB);
    // 4: intervening store to linked / other address
    data_op(2, 32'h200, 0);
    data_op(1, 32'h200, 32'h11);
    data_op(3, 32'h200, 32'h22);
    data_op(2, 32'h200, 0);
    data_op(1, 32'h204, 32'h33);
    data_op(3, 32'h200, 32'h44);
    data_op(0, 32'h200, 0);

    // 5: reset during a stalled access
    data_op(2, 32'h200, 0);
    rdy_mode = 2;
    dREN = 1; dWEN = 0; datomic = 0; daddr = 32'h208;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_in_dacc", 32'(ramREN), 1);
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1;
    m_lv = 0;
    @(negedge CLK);
    chk("t5_rst_dhit", 32'(dhit), 0);
    chk("t5_rst_ram", {30'd0, ramREN, ramWEN}, 0);
    @(posedge CLK); #1;
    RST = 0; dREN = 0; daddr = '0;
    @(negedge CLK);
    chk("t5_idle_after", {29'd0, ihit, dhit, ramREN}, 0);
    chk("t5_idle_ramaddr", ramaddr, 0);
    @(posedge CLK); #1;
    rdy_mode = 1;
    data_op(3, 32'h200, 32'h55);
    data_drop();

    // 6: random mixed traffic with random ram_ready
    rdy_mode = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            iREN = 0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
          end
          inst_op(32'h1000 + 4 * $urandom_range(0, 63));
        end
        iREN = 0;
      end
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            data_drop();
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
          end
          data_op($urandom_range(0, 3), 32'h200 + 4 * $urandom_range(0, 3), $urandom);
        end
        data_drop();
      end
    join

    repeat (3) @(posedge CLK);
    #1;
    chk("iq_drained", 32'(iq.size()), 0);
    chk("dq_drained", 32'(dq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
